// File: rtl/irq_prio_pkg.sv
// Shared types and constants for the 8-channel interrupt priority controller.
package irq_prio_pkg;

  localparam int NUM_CH = 8;
  localparam int VEC_W  = 3;

  localparam logic [NUM_CH-1:0] MASK_RST = 8'h00;
  localparam logic [NUM_CH-1:0] SYNC_RST = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } state_t;

  // One-hot bit for a channel index, used to retire the serviced request.
  function automatic logic [NUM_CH-1:0] chan_bit(input logic [VEC_W-1:0] idx);
    return {{(NUM_CH-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/prio_enc8.sv
// Combinational 8-to-3 priority encoder, active-high inputs, highest index wins.
module prio_enc8
  import irq_prio_pkg::*;
(
  input  logic [NUM_CH-1:0] d,
  output logic              none,
  output logic [VEC_W-1:0]  idx
);

  // Ascending scan so the last (highest) set bit overrides lower ones.
  always_comb begin
    idx = {VEC_W{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      idx = d[i] ? VEC_W'(i) : idx;
    end
  end

  assign none = (d == {NUM_CH{1'b0}});

endmodule

// File: rtl/irq_prio_ctrl.sv
// Interrupt controller: synchronizes active-low requests, latches them as pending,
// masks them and offers the highest-priority channel to the CPU via int_n/ack/eoi.
module irq_prio_ctrl
  import irq_prio_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE_MODE   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req_n,
  input  logic              mask_wr,
  input  logic [NUM_CH-1:0] mask_din,
  output logic [NUM_CH-1:0] mask_q,
  output logic [NUM_CH-1:0] pending_q,
  output logic              int_n,
  output logic [VEC_W-1:0]  vec,
  output logic              vec_valid,
  input  logic              ack,
  input  logic              eoi,
  output logic              busy
);

  logic [NUM_CH-1:0] sync_r [SYNC_STAGES];
  logic [NUM_CH-1:0] hist_r;
  logic [NUM_CH-1:0] pend_r;
  logic [NUM_CH-1:0] mask_r;
  logic [NUM_CH-1:0] s_req_n_s;
  logic [NUM_CH-1:0] set_s;
  logic [NUM_CH-1:0] clr_s;
  logic [NUM_CH-1:0] pend_nxt_s;
  logic [NUM_CH-1:0] cand_s;
  logic              ack_ok_s;
  logic              none_s;
  logic [VEC_W-1:0]  idx_s;

  state_t            state_r;
  logic              int_n_r;
  logic [VEC_W-1:0]  vec_r;
  logic              vec_valid_r;
  logic              busy_r;

  // Request synchronizer chain plus one-cycle history of its output for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= SYNC_RST;
      end
      hist_r <= SYNC_RST;
    end else begin
      sync_r[0] <= req_n;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
      hist_r <= sync_r[SYNC_STAGES-1];
    end
  end

  // Set has priority over the ack-driven clear so a re-arriving event is never lost.
  always_comb begin
    s_req_n_s  = sync_r[SYNC_STAGES-1];
    set_s      = EDGE_MODE ? (~s_req_n_s & hist_r) : ~s_req_n_s;
    ack_ok_s   = (state_r == REQ) && ack;
    clr_s      = ack_ok_s ? chan_bit(vec_r) : {NUM_CH{1'b0}};
    pend_nxt_s = (pend_r & ~clr_s) | set_s;
    cand_s     = pend_r & ~mask_r;
  end

  prio_enc8 u_enc (
    .d    (cand_s),
    .none (none_s),
    .idx  (idx_s)
  );

  // Pending and mask registers; the mask only gates selection, never latching.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_r <= {NUM_CH{1'b0}};
      mask_r <= MASK_RST;
    end else begin
      pend_r <= pend_nxt_s;
      if (mask_wr) begin
        mask_r <= mask_din;
      end
    end
  end

  // CPU handshake sequencer with registered int_n/vec/vec_valid/busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      int_n_r     <= 1'b1;
      vec_r       <= {VEC_W{1'b0}};
      vec_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (!none_s) begin
            state_r     <= REQ;
            vec_r       <= idx_s;
            int_n_r     <= 1'b0;
            vec_valid_r <= 1'b1;
          end
        end
        REQ: begin
          if (ack) begin
            state_r     <= SERV;
            int_n_r     <= 1'b1;
            vec_valid_r <= 1'b0;
            busy_r      <= 1'b1;
          end else if (none_s) begin
            state_r     <= IDLE;
            int_n_r     <= 1'b1;
            vec_valid_r <= 1'b0;
          end else begin
            vec_r <= idx_s;
          end
        end
        SERV: begin
          if (eoi) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          int_n_r     <= 1'b1;
          vec_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign mask_q    = mask_r;
  assign pending_q = pend_r;
  assign int_n     = int_n_r;
  assign vec       = vec_r;
  assign vec_valid = vec_valid_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_irq_prio_ctrl.sv
// Scoreboard bench for irq_prio_ctrl: directed scenarios then random traffic,
// checked cycle by cycle against a behavioural reference model.
module tb_irq_prio_ctrl;

  localparam int SYNC = 2;
  localparam bit EDGE = 1'b1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req_n;
  logic       mask_wr;
  logic [7:0] mask_din;
  logic [7:0] mask_q;
  logic [7:0] pending_q;
  logic       int_n;
  logic [2:0] vec;
  logic       vec_valid;
  logic       ack;
  logic       eoi;
  logic       busy;

  irq_prio_ctrl #(.SYNC_STAGES(SYNC), .EDGE_MODE(EDGE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_n     (req_n),
    .mask_wr   (mask_wr),
    .mask_din  (mask_din),
    .mask_q    (mask_q),
    .pending_q (pending_q),
    .int_n     (int_n),
    .vec       (vec),
    .vec_valid (vec_valid),
    .ack       (ack),
    .eoi       (eoi),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       int_n;
    logic [2:0] vec;
    logic       vv;
    logic       busy;
    logic [7:0] pend;
    logic [7:0] mask;
    logic       has_dir;
    logic       d_int_n;
    logic [2:0] d_vec;
    logic       d_vv;
    logic       d_busy;
    logic [7:0] d_pend;
  } snap_t;

  snap_t sb[$];
  int checks   = 0;
  int failures = 0;

  // Reference model state: phase 0 = idle, 1 = offering, 2 = in service.
  logic [7:0] m_q[$];
  logic [7:0] m_prev;
  logic [7:0] m_pend;
  logic [7:0] m_mask;
  int         m_ph;
  logic [2:0] m_vec;

  task automatic model_reset();
    m_q = {};
    for (int i = 0; i < SYNC; i++) m_q.push_back(8'hFF);
    m_prev = 8'hFF;
    m_pend = 8'h00;
    m_mask = 8'h00;
    m_ph   = 0;
    m_vec  = 3'd0;
  endtask

  task automatic model_step();
    logic [7:0] s, cand, ev, nxt;
    int top;
    bit acc;
    if (!rst_n) begin
      model_reset();
      return;
    end
    s    = m_q[0];
    cand = m_pend & ~m_mask;
    top  = -1;
    for (int i = 0; i < 8; i++) if (cand[i]) top = i;
    ev  = EDGE ? (~s & m_prev) : ~s;
    acc = (m_ph == 1) && ack;
    nxt = m_pend;
    if (acc) nxt[m_vec] = 1'b0;
    nxt = nxt | ev;
    if (m_ph == 0) begin
      if (top >= 0) begin m_ph = 1; m_vec = 3'(top); end
    end else if (m_ph == 1) begin
      if (acc) m_ph = 2;
      else if (top < 0) m_ph = 0;
      else m_vec = 3'(top);
    end else begin
      if (eoi) m_ph = 0;
    end
    if (mask_wr) m_mask = mask_din;
    m_pend = nxt;
    m_prev = s;
    void'(m_q.pop_front());
    m_q.push_back(req_n);
  endtask

  task automatic cyc(input int n);
    snap_t e;
    repeat (n) begin
      @(posedge clk);
      model_step();
      e = '{int_n: (m_ph != 1), vec: m_vec, vv: (m_ph == 1), busy: (m_ph == 2),
            pend: m_pend, mask: m_mask, has_dir: 1'b0, d_int_n: 1'b0, d_vec: 3'd0,
            d_vv: 1'b0, d_busy: 1'b0, d_pend: 8'h00};
      sb.push_back(e);
      #1;
    end
  endtask

  // Attach constant expectations to the most recent cycle's snapshot.
  task automatic expect_dir(input logic i_n, input logic [2:0] v, input logic vv,
                            input logic b, input logic [7:0] p);
    int k;
    k = sb.size() - 1;
    sb[k].has_dir = 1'b1;
    sb[k].d_int_n = i_n;
    sb[k].d_vec   = v;
    sb[k].d_vv    = vv;
    sb[k].d_busy  = b;
    sb[k].d_pend  = p;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  snap_t me;
  // Monitor: compares DUT outputs every falling edge, and immediately on reset assertion.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      #1;
      if (sb.size() > 0) me = sb.pop_front();
      chk("rst_int_n", {7'd0, int_n}, 8'h01);
      chk("rst_vec", {5'd0, vec}, 8'h00);
      chk("rst_vec_valid", {7'd0, vec_valid}, 8'h00);
      chk("rst_busy", {7'd0, busy}, 8'h00);
      chk("rst_pending", pending_q, 8'h00);
      chk("rst_mask", mask_q, 8'h00);
    end else if (sb.size() > 0) begin
      me = sb.pop_front();
      chk("int_n", {7'd0, int_n}, {7'd0, me.int_n});
      chk("vec", {5'd0, vec}, {5'd0, me.vec});
      chk("vec_valid", {7'd0, vec_valid}, {7'd0, me.vv});
      chk("busy", {7'd0, busy}, {7'd0, me.busy});
      chk("pending_q", pending_q, me.pend);
      chk("mask_q", mask_q, me.mask);
      if (me.has_dir) begin
        chk("dir_int_n", {7'd0, int_n}, {7'd0, me.d_int_n});
        chk("dir_vec", {5'd0, vec}, {5'd0, me.d_vec});
        chk("dir_vec_valid", {7'd0, vec_valid}, {7'd0, me.d_vv});
        chk("dir_busy", {7'd0, busy}, {7'd0, me.d_busy});
        chk("dir_pending", pending_q, me.d_pend);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_n = 8'hFF; mask_wr = 1'b0; mask_din = 8'h00; ack = 1'b0; eoi = 1'b0;
    model_reset();
    cyc(3);
    expect_dir(1'b1, 3'd0, 1'b0, 1'b0, 8'h00);
    rst_n = 1'b1;
    cyc(2);

    // Single request on channel 2, ack, eoi.
    req_n = 8'hFB;
    cyc(3); expect_dir(1'b1, 3'd0, 1'b0, 1'b0, 8'h04);
    cyc(1); expect_dir(1'b0, 3'd2, 1'b1, 1'b0, 8'h04);
    ack = 1'b1; cyc(1); ack = 1'b0; expect_dir(1'b1, 3'd2, 1'b0, 1'b1, 8'h00);
    eoi = 1'b1; cyc(1); eoi = 1'b0; expect_dir(1'b1, 3'd2, 1'b0, 1'b0, 8'h00);
    req_n = 8'hFF; cyc(3);

    // Channels 1 and 5 together: 5 first, then 1.
    req_n = 8'hDD;
    cyc(4); expect_dir(1'b0, 3'd5, 1'b1, 1'b0, 8'h22);
    ack = 1'b1; cyc(1); ack = 1'b0; expect_dir(1'b1, 3'd5, 1'b0, 1'b1, 8'h02);
    eoi = 1'b1; cyc(1); eoi = 1'b0; expect_dir(1'b1, 3'd5, 1'b0, 1'b0, 8'h02);
    cyc(1); expect_dir(1'b0, 3'd1, 1'b1, 1'b0, 8'h02);
    ack = 1'b1; cyc(1); ack = 1'b0; expect_dir(1'b1, 3'd1, 1'b0, 1'b1, 8'h00);
    eoi = 1'b1; cyc(1); eoi = 1'b0;
    req_n = 8'hFF; cyc(3);

    // Preemption of channel 3 by channel 6 before ack.
    req_n = 8'hF7;
    cyc(4); expect_dir(1'b0, 3'd3, 1'b1, 1'b0, 8'h08);
    req_n = 8'hB7;
    cyc(3); expect_dir(1'b0, 3'd3, 1'b1, 1'b0, 8'h48);
    cyc(1); expect_dir(1'b0, 3'd6, 1'b1, 1'b0, 8'h48);
    ack = 1'b1; cyc(1); ack = 1'b0; expect_dir(1'b1, 3'd6, 1'b0, 1'b1, 8'h08);
    eoi = 1'b1; cyc(1); eoi = 1'b0;
    cyc(1); expect_dir(1'b0, 3'd3, 1'b1, 1'b0, 8'h08);
    ack = 1'b1; cyc(1); ack = 1'b0;
    eoi = 1'b1; cyc(1); eoi = 1'b0;
    req_n = 8'hFF; cyc(3);

    // Masking a pending channel withdraws the offer without losing it.
    req_n = 8'hEF;
    cyc(4); expect_dir(1'b0, 3'd4, 1'b1, 1'b0, 8'h10);
    mask_wr = 1'b1; mask_din = 8'h10; cyc(1); mask_wr = 1'b0;
    cyc(1); expect_dir(1'b1, 3'd4, 1'b0, 1'b0, 8'h10);
    mask_wr = 1'b1; mask_din = 8'h00; cyc(1); mask_wr = 1'b0;
    expect_dir(1'b1, 3'd4, 1'b0, 1'b0, 8'h10);
    cyc(1); expect_dir(1'b0, 3'd4, 1'b1, 1'b0, 8'h10);
    ack = 1'b1; cyc(1); ack = 1'b0;
    eoi = 1'b1; cyc(1); eoi = 1'b0;
    req_n = 8'hFF; cyc(3);

    // Re-edge coinciding with ack; stray eoi in REQ, ack+eoi together, stray ack in IDLE.
    req_n = 8'hFB;
    cyc(4); expect_dir(1'b0, 3'd2, 1'b1, 1'b0, 8'h04);
    req_n = 8'hFF; cyc(3);
    req_n = 8'hFB; cyc(2);
    ack = 1'b1; cyc(1); ack = 1'b0; expect_dir(1'b1, 3'd2, 1'b0, 1'b1, 8'h04);
    eoi = 1'b1; cyc(1); eoi = 1'b0; expect_dir(1'b1, 3'd2, 1'b0, 1'b0, 8'h04);
    cyc(1); expect_dir(1'b0, 3'd2, 1'b1, 1'b0, 8'h04);
    eoi = 1'b1; cyc(1); eoi = 1'b0; expect_dir(1'b0, 3'd2, 1'b1, 1'b0, 8'h04);
    ack = 1'b1; eoi = 1'b1; cyc(1); ack = 1'b0; eoi = 1'b0;
    expect_dir(1'b1, 3'd2, 1'b0, 1'b1, 8'h00);
    eoi = 1'b1; cyc(1); eoi = 1'b0;
    ack = 1'b1; cyc(1); ack = 1'b0; expect_dir(1'b1, 3'd2, 1'b0, 1'b0, 8'h00);
    req_n = 8'hFF; cyc(3);

    // Asynchronous reset in SERV with pending 8'h81.
    req_n = 8'h7E;
    cyc(4); expect_dir(1'b0, 3'd7, 1'b1, 1'b0, 8'h81);
    ack = 1'b1; cyc(1); ack = 1'b0; expect_dir(1'b1, 3'd7, 1'b0, 1'b1, 8'h01);
    req_n = 8'hFE; cyc(3);
    req_n = 8'h7E; cyc(3); expect_dir(1'b1, 3'd7, 1'b0, 1'b1, 8'h81);
    #2; rst_n = 1'b0;
    req_n = 8'hFF;
    cyc(2);
    rst_n = 1'b1;
    cyc(6); expect_dir(1'b1, 3'd0, 1'b0, 1'b0, 8'h00);

    // Random traffic with sparse request toggles, mask writes and handshakes.
    for (int n = 0; n < 1500; n++) begin
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, 7) == 0) req_n[b] = ~req_n[b];
      end
      mask_wr  = ($urandom_range(0, 31) == 0);
      mask_din = 8'($urandom);
      ack      = ($urandom_range(0, 3) == 0);
      eoi      = ($urandom_range(0, 3) == 0);
      cyc(1);
    end
    req_n = 8'hFF; mask_wr = 1'b0; ack = 1'b0; eoi = 1'b0;
    cyc(5);
    @(negedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
